// File: rtl/onchip_sram_pkg.sv
// Shared types and constants for the dual-port on-chip SRAM.
package onchip_sram_pkg;

    // Controller state: zero-filling after reset, or serving requests.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } sram_state_t;

    // Legal read latencies, in cycles from acceptance to readdatavalid.
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

endpackage

// File: rtl/sram_dp_core.sv
// True-dual-port storage array with per-byte-lane write enables and a
// registered read on each port. No control logic lives here.
module sram_dp_core #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    localparam int BE_W  = DATA_W / 8,
    localparam int DEPTH = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [BE_W-1:0]   we_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [BE_W-1:0]   we_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Lane writes and registered reads for both ports. Port A is applied last
    // so it would win any lane collision, although the top level already masks
    // colliding lanes off port B.
    // NOTE: the array has no reset term -- a reset on every word would stop it
    // from mapping onto block RAM; zero-filling is done by the controller.
    // NOTE: non-blocking assignments mean each read samples the array as it was
    // before this edge's writes, which gives read-old-data on collisions.
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < BE_W; lane++) begin
            if (we_b[lane]) mem[addr_b][lane*8 +: 8] <= wdata_b[lane*8 +: 8];
            if (we_a[lane]) mem[addr_a][lane*8 +: 8] <= wdata_a[lane*8 +: 8];
        end
        rdata_a <= mem[addr_a];
        rdata_b <= mem[addr_b];
    end

endmodule

// File: rtl/onchip_sram_dual_port.sv
// Dual Avalon-MM slave on-chip SRAM: post-reset zero fill, write arbitration
// between the two ports, and a 1- or 2-cycle read latency pipeline.
module onchip_sram_dual_port
    import onchip_sram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 14,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int BE_W          = DATA_W / 8,
    localparam int DEPTH         = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [ADDR_W-1:0] address2,
    input  logic [BE_W-1:0]   byteenable,
    input  logic [BE_W-1:0]   byteenable2,
    input  logic              chipselect,
    input  logic              chipselect2,
    input  logic              read,
    input  logic              read2,
    input  logic              write,
    input  logic              write2,
    input  logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] writedata2,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] readdata2,
    output logic              readdatavalid,
    output logic              readdatavalid2,
    output logic              waitrequest,
    output logic              waitrequest2,
    output logic              init_done
);

    sram_state_t       state, state_next;
    logic [ADDR_W-1:0] clr_addr;
    logic              run;
    logic              clear_we;

    logic              wr_a, rd_a, wr_b, rd_b;
    logic [BE_W-1:0]   be_b_masked;

    logic [ADDR_W-1:0] core_addr_a;
    logic [BE_W-1:0]   core_we_a, core_we_b;
    logic [DATA_W-1:0] core_wdata_a;
    logic [DATA_W-1:0] q_a, q_b;

    logic              rv1_a, rv1_b;
    logic              vf_a, vf_b;
    logic [DATA_W-1:0] df_a, df_b;
    logic [DATA_W-1:0] hold_a, hold_b;

    // Next-state logic: leave CLEAR once the last word has been zeroed.
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        run        = 1'b0;
        case (state)
            CLEAR:   if (clr_addr == ADDR_W'(DEPTH - 1)) state_next = RUN;
            RUN:     run = 1'b1;
            default: state_next = state;
        endcase
    end

    // State register and clear counter; reset restarts clearing at address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_addr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
        end
    end

    // Both slaves stall together while resetting or clearing.
    assign waitrequest  = reset | ~run;
    assign waitrequest2 = waitrequest;
    assign init_done    = ~reset & run;

    // Request acceptance; a write on the same port suppresses the read.
    assign wr_a = chipselect  & write  & ~waitrequest;
    assign rd_a = chipselect  & read   & ~write  & ~waitrequest;
    assign wr_b = chipselect2 & write2 & ~waitrequest2;
    assign rd_b = chipselect2 & read2  & ~write2 & ~waitrequest2;

    // Port 1 owns overlapping lanes when both ports write one address.
    assign be_b_masked = (wr_a && (address2 == address)) ? (byteenable2 & ~byteenable)
                                                          : byteenable2;

    // The clear engine borrows port A of the array while clearing.
    assign clear_we     = (state == CLEAR) & ~reset;
    assign core_addr_a  = clear_we ? clr_addr : address;
    assign core_we_a    = clear_we ? '1 : (wr_a ? byteenable : '0);
    assign core_wdata_a = clear_we ? '0 : writedata;
    assign core_we_b    = wr_b ? be_b_masked : '0;

    sram_dp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .addr_a  (core_addr_a),
        .we_a    (core_we_a),
        .wdata_a (core_wdata_a),
        .rdata_a (q_a),
        .addr_b  (address2),
        .we_b    (core_we_b),
        .wdata_b (writedata2),
        .rdata_b (q_b)
    );

    // First latency stage: track which array outputs belong to accepted reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rv1_a <= 1'b0;
            rv1_b <= 1'b0;
        end else begin
            rv1_a <= rd_a;
            rv1_b <= rd_b;
        end
    end

    if (READ_LATENCY >= READ_LATENCY_MAX) begin : g_lat2
        logic              rv2_a, rv2_b;
        logic [DATA_W-1:0] d2_a, d2_b;

        // Second stage valid flags, flushed by reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                rv2_a <= 1'b0;
                rv2_b <= 1'b0;
            end else begin
                rv2_a <= rv1_a;
                rv2_b <= rv1_b;
            end
        end

        // Second stage data; qualified by the valid flags, so no reset needed.
        always_ff @(posedge clk) begin
            d2_a <= q_a;
            d2_b <= q_b;
        end

        assign vf_a = rv2_a;
        assign vf_b = rv2_b;
        assign df_a = d2_a;
        assign df_b = d2_b;
    end else begin : g_lat1
        assign vf_a = rv1_a;
        assign vf_b = rv1_b;
        assign df_a = q_a;
        assign df_b = q_b;
    end

    // Remember the last delivered word so readdata holds between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            if (vf_a) hold_a <= df_a;
            if (vf_b) hold_b <= df_b;
        end
    end

    // Reset masks the outputs immediately so no strobe escapes a flush.
    assign readdatavalid  = vf_a & ~reset;
    assign readdatavalid2 = vf_b & ~reset;
    assign readdata       = reset ? '0 : (vf_a ? df_a : hold_a);
    assign readdata2      = reset ? '0 : (vf_b ? df_b : hold_b);

endmodule

// File: tb/tb_onchip_sram_dual_port.sv
// Self-checking bench: two DUTs (READ_LATENCY 1 and 2, ADDR_W 4) share one
// stimulus stream; read results are scoreboarded per DUT and port.
module tb_onchip_sram_dual_port;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int BW = DW / 8;

    typedef struct packed {
        logic          cs;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } req_t;

    typedef struct {
        req_t          a;
        req_t          b;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } sb_t;

    localparam req_t IDLE = '0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] addr_a, addr_b;
    logic [BW-1:0] be_a, be_b;
    logic          cs_a, cs_b, rd_a, rd_b, wr_a, wr_b;
    logic [DW-1:0] wd_a, wd_b;

    logic [DW-1:0] rdata  [2][2];
    logic          rvalid [2][2];
    logic          wreq   [2][2];
    logic          init   [2];

    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    sb_t sbq [2][2][$];
    logic [DW-1:0] last [2][2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    onchip_sram_dual_port #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_dut_l1 (
        .clk(clk), .reset(reset),
        .address(addr_a), .address2(addr_b),
        .byteenable(be_a), .byteenable2(be_b),
        .chipselect(cs_a), .chipselect2(cs_b),
        .read(rd_a), .read2(rd_b),
        .write(wr_a), .write2(wr_b),
        .writedata(wd_a), .writedata2(wd_b),
        .readdata(rdata[0][0]), .readdata2(rdata[0][1]),
        .readdatavalid(rvalid[0][0]), .readdatavalid2(rvalid[0][1]),
        .waitrequest(wreq[0][0]), .waitrequest2(wreq[0][1]),
        .init_done(init[0])
    );

    onchip_sram_dual_port #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .address(addr_a), .address2(addr_b),
        .byteenable(be_a), .byteenable2(be_b),
        .chipselect(cs_a), .chipselect2(cs_b),
        .read(rd_a), .read2(rd_b),
        .write(wr_a), .write2(wr_b),
        .writedata(wd_a), .writedata2(wd_b),
        .readdata(rdata[1][0]), .readdata2(rdata[1][1]),
        .readdatavalid(rvalid[1][0]), .readdatavalid2(rvalid[1][1]),
        .waitrequest(wreq[1][0]), .waitrequest2(wreq[1][1]),
        .init_done(init[1])
    );

    function automatic int lat(input int d);
        return d + 1;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic req_t wrq(input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
        req_t r = '{cs: 1'b1, rd: 1'b0, wr: 1'b1, addr: a, be: be, data: d};
        return r;
    endfunction

    function automatic req_t rdq(input logic [AW-1:0] a);
        req_t r = '{cs: 1'b1, rd: 1'b1, wr: 1'b0, addr: a, be: '0, data: '0};
        return r;
    endfunction

    task automatic apply(input req_t a, input req_t b);
        cs_a = a.cs; rd_a = a.rd; wr_a = a.wr; addr_a = a.addr; be_a = a.be; wd_a = a.data;
        cs_b = b.cs; rd_b = b.rd; wr_b = b.wr; addr_b = b.addr; be_b = b.be; wd_b = b.data;
    endtask

    // One accepted cycle of stimulus; expected read data goes to the scoreboard.
    task automatic drive(input req_t a, input req_t b, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        apply(a, b);
        for (int d = 0; d < 2; d++) begin
            if (a.cs && a.rd && !a.wr) sbq[d][0].push_back('{data: ea, due: cyc + lat(d)});
            if (b.cs && b.rd && !b.wr) sbq[d][1].push_back('{data: eb, due: cyc + lat(d)});
        end
        @(posedge clk); #1;
        apply(IDLE, IDLE);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        apply(IDLE, IDLE);
        repeat (n) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                check($sformatf("d%0d reset {wait,wait2,init}", d),
                      32'({wreq[d][0], wreq[d][1], init[d]}), 32'b110);
            @(posedge clk);
        end
        #1 reset = 1'b0;
    endtask

    // Called just after reset release: 16 stalled cycles, ready on the 17th.
    task automatic check_clear_seq(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                check($sformatf("%s d%0d clear cycle %0d {wait,wait2,init}", tag, d, i),
                      32'({wreq[d][0], wreq[d][1], init[d]}), 32'b110);
            @(posedge clk);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("%s d%0d ready {wait,wait2,init}", tag, d),
                  32'({wreq[d][0], wreq[d][1], init[d]}), 32'b001);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string tag);
        repeat (4) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                check($sformatf("%s d%0d p%0d pending reads", tag, d, p), 32'(sbq[d][p].size()), 32'd0);
    endtask

    // Output monitor: strobes must match the scoreboard in data and cycle,
    // readdata must hold between strobes, and reset forces quiet outputs.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (reset) begin
                    check($sformatf("d%0d p%0d readdata in reset", d, p), rdata[d][p], '0);
                    check($sformatf("d%0d p%0d readdatavalid in reset", d, p), 32'(rvalid[d][p]), 32'd0);
                    last[d][p] = '0;
                end else if (rvalid[d][p]) begin
                    if (sbq[d][p].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL d%0d p%0d unexpected readdatavalid: got 1, expected 0 (t=%0t)", d, p, $time);
                    end else begin
                        sb_t e;
                        e = sbq[d][p].pop_front();
                        check($sformatf("d%0d p%0d read data", d, p), rdata[d][p], e.data);
                        check($sformatf("d%0d p%0d read cycle", d, p), 32'(cyc), 32'(e.due));
                        last[d][p] = e.data;
                    end
                end else begin
                    check($sformatf("d%0d p%0d readdata hold", d, p), rdata[d][p], last[d][p]);
                    if (sbq[d][p].size() > 0 && sbq[d][p][0].due <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL d%0d p%0d missing readdatavalid: got 0, expected 1 at cycle %0d", d, p, sbq[d][p][0].due);
                        void'(sbq[d][p].pop_front());
                    end
                end
            end
        end
    end

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        req_t rw;

        // Port A / port B stimulus with the read data each accepted read must return.
        vecs[0]  = '{wrq(5, 4'hF, 32'hDEADBEEF), IDLE, 32'h0, 32'h0};
        vecs[1]  = '{wrq(5, 4'h1, 32'h000000AA), IDLE, 32'h0, 32'h0};
        vecs[2]  = '{rdq(5), IDLE, 32'hDEADBEAA, 32'h0};
        vecs[3]  = '{IDLE, wrq(9, 4'hF, 32'hCAFEF00D), 32'h0, 32'h0};
        vecs[4]  = '{rdq(9), rdq(5), 32'hCAFEF00D, 32'hDEADBEAA};
        vecs[5]  = '{wrq(7, 4'h3, 32'h11111111), wrq(7, 4'hF, 32'h22222222), 32'h0, 32'h0};
        vecs[6]  = '{rdq(7), rdq(7), 32'h22221111, 32'h22221111};
        vecs[7]  = '{rdq(9), wrq(9, 4'hC, 32'h12345678), 32'hCAFEF00D, 32'h0};
        vecs[8]  = '{IDLE, rdq(9), 32'h0, 32'h1234F00D};
        rw = wrq(3, 4'hF, 32'hA5A5A5A5);
        rw.rd = 1'b1;
        vecs[9]  = '{rw, IDLE, 32'h0, 32'h0};
        vecs[10] = '{rdq(3), IDLE, 32'hA5A5A5A5, 32'h0};
        vecs[11] = '{IDLE, wrq(3, 4'h0, 32'hFFFFFFFF), 32'h0, 32'h0};
        vecs[12] = '{wrq(2, 4'h4, 32'h00FF0000), rdq(3), 32'h0, 32'hA5A5A5A5};
        vecs[13] = '{rdq(2), wrq(2, 4'h8, 32'h77000000), 32'h00FF0000, 32'h0};
        vecs[14] = '{IDLE, rdq(2), 32'h0, 32'h77FF0000};
        rw = wrq(2, 4'hF, 32'h0);
        rw.cs = 1'b0;
        vecs[15] = '{rw, IDLE, 32'h0, 32'h0};
        rw = rdq(2);
        rw.cs = 1'b0;
        vecs[16] = '{rdq(2), rw, 32'h77FF0000, 32'h0};

        apply(IDLE, IDLE);
        do_reset(3);
        check_clear_seq("power-up");

        // Every word reads back zero after the fill, both ports, back to back.
        for (int i = 0; i < 16; i++)
            drive(rdq(AW'(i)), rdq(AW'(15 - i)), 32'h0, 32'h0);
        drain("zero-fill");

        for (int i = 0; i < NV; i++)
            drive(vecs[i].a, vecs[i].b, vecs[i].exp_a, vecs[i].exp_b);
        drain("table");

        // Back-to-back reads of 1, 2, 3 on port A: consecutive strobes in order.
        drive(rdq(1), IDLE, 32'h0, 32'h0);
        drive(rdq(2), IDLE, 32'h77FF0000, 32'h0);
        drive(rdq(3), IDLE, 32'hA5A5A5A5, 32'h0);
        drain("burst");

        // A read accepted, then reset on the following edge: it must never strobe.
        apply(rdq(5), IDLE);
        @(posedge clk); #1;
        do_reset(2);

        // Reset again part-way through clearing; the fill must start over.
        repeat (5) @(posedge clk);
        #1;
        do_reset(1);
        check_clear_seq("re-clear");

        drive(rdq(5), rdq(9), 32'h0, 32'h0);
        drive(rdq(7), rdq(3), 32'h0, 32'h0);
        drain("after re-clear");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/onchip_sram_dual_port.md
ONCHIP_SRAM_DUAL_PORT -- requirements
Module: onchip_sram_dual_port

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter DATA_W SHALL default to 32 and set the word width; it SHALL be a multiple of 8, giving BE_W = DATA_W/8.
REQ-003 Parameter ADDR_W SHALL default to 14, giving DEPTH = 2**ADDR_W words.
REQ-004 Parameter READ_LATENCY SHALL default to 1, with legal values 1 or 2 cycles from read acceptance to readdatavalid.
REQ-005 Parameter CLEAR_ON_RESET SHALL default to 1; 1 zero-fills the memory after every reset.
REQ-006 The ports SHALL be, in this order (suffix 2 = second Avalon slave; unsuffixed = first):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- address, address2  in  ADDR_W  word address
- byteenable, byteenable2  in  BE_W  write lane enables
- chipselect, chipselect2  in  1  slave select
- read, read2  in  1  read request
- write, write2  in  1  write request
- writedata, writedata2  in  DATA_W  write data
- readdata, readdata2  out  DATA_W  read data
- readdatavalid, readdatavalid2  out  1  one-cycle read-data strobe
- waitrequest, waitrequest2  out  1  request stall
- init_done  out  1  high once the memory is usable

Function
REQ-007 The FSM SHALL have two states, CLEAR and RUN; reset SHALL enter CLEAR when CLEAR_ON_RESET=1 and RUN otherwise.
REQ-008 In CLEAR, a counter SHALL write zero to address 0..DEPTH-1, one word per cycle, all lanes enabled, and SHALL move to RUN in the cycle after writing DEPTH-1.
REQ-009 In CLEAR, waitrequest and waitrequest2 SHALL be 1 and init_done SHALL be 0, with all requests ignored.
REQ-010 In RUN, waitrequest and waitrequest2 SHALL be 0 and init_done SHALL be 1.
REQ-011 A request SHALL be accepted on a rising edge where chipselect is 1 and waitrequest is 0, per port.
REQ-012 An accepted write SHALL update only the lanes whose byteenable bit is 1; byteenable = 0 SHALL leave memory unchanged.
REQ-013 An accepted read SHALL drive readdata with readdatavalid = 1 for exactly one cycle, READ_LATENCY cycles after acceptance.
REQ-014 Reads SHALL be fully pipelined at one per cycle per port.
REQ-015 readdata SHALL hold its last value between strobes.
REQ-016 If read and write are both 1 on one port, the write SHALL be performed and the read dropped, with no readdatavalid.
REQ-017 If both ports write the same address in one cycle, the first port SHALL win on overlapping lanes, and the second port's non-overlapping lanes SHALL still be written (byteenable2 masked by ~byteenable).
REQ-018 A read SHALL return data reflecting all writes accepted in earlier cycles.
REQ-019 A mixed-port read and write to the same address in the same cycle SHALL return the old data.
REQ-020 Addresses SHALL be taken modulo DEPTH, with no out-of-range error.

Reset
REQ-021 While reset = 1: readdata = 0, readdatavalid = 0, waitrequest = 1, init_done = 0, and the clear counter = 0.
REQ-022 Reset mid-operation SHALL flush all in-flight reads, so no readdatavalid follows reset; memory contents SHALL be undefined unless CLEAR re-runs.
REQ-023 Reset asserted during CLEAR SHALL restart clearing at address 0.

Structure
REQ-024 Package onchip_sram_pkg SHALL hold the state enum (CLEAR, RUN) and the legal-READ_LATENCY constant.
REQ-025 Storage SHALL be a sub-module, sram_dp_core: a pure inferred true-dual-port array with per-lane write enables and a registered read; control, arbitration and the latency pipeline SHALL stay in the top level.

Verification
REQ-026 ADDR_W=4, CLEAR_ON_RESET=1: reset released -> waitrequest high for 16 cycles, init_done rises on cycle 17, and reads of addresses 0..15 all return 0.
REQ-027 Write 0xDEADBEEF to address 5 with byteenable 0xF, then 0x000000AA with byteenable 0x1, then read address 5 -> returns 0xDEADBEAA after READ_LATENCY cycles.
REQ-028 READ_LATENCY=2, back-to-back reads of addresses 1, 2, 3 -> readdatavalid high for 3 consecutive cycles starting 2 cycles after the first acceptance, with data in order.
REQ-029 Same-cycle writes to address 7: port 1 writes 0x11111111 with byteenable 0x3; port 2 writes 0x22222222 with byteenable 0xF -> read returns 0x22221111.
REQ-030 Issue a read, then assert reset on the next edge -> no readdatavalid occurs, readdata = 0, and CLEAR restarts from address 0.
